// File: rtl/multi_clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   BOARD_CLK_DEF : default board clock frequency in Hz
//   mode_e        : per-channel output mode (toggle / pulse)
//   clog2         : ceiling log2 for elaboration-time sizing
//   sel_width     : width of the channel-select field, at least 1 bit
package multi_clk_div_pkg;

  localparam int unsigned BOARD_CLK_DEF = 50_000_000;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  function automatic int clog2(int unsigned n);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int sel_width(int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/multi_clk_div_if.sv
// Control/status bundle of the multi-channel clock divider.
//   En, Mode      : per-channel enable and mode (0 toggle, 1 pulse)
//   LdStb/Sel/Val : one-cycle divisor load into a channel's shadow register
//   Sync          : synchronous restart of all channels
//   ClkOut/Tick   : registered divided output and terminal-count strobe
//   Pend          : a shadow divisor is waiting to be applied
// master drives the controls (system side), slave is the divider.
interface multi_clk_div_if #(
  parameter int NCH  = 4,
  parameter int CW   = 26,
  parameter int SELW = 2
);
  logic [NCH-1:0]  En;
  logic [NCH-1:0]  Mode;
  logic            LdStb;
  logic [SELW-1:0] LdSel;
  logic [CW-1:0]   LdVal;
  logic            Sync;
  logic [NCH-1:0]  ClkOut;
  logic [NCH-1:0]  Tick;
  logic [NCH-1:0]  Pend;

  modport master (
    output En, Mode, LdStb, LdSel, LdVal, Sync,
    input  ClkOut, Tick, Pend
  );

  modport slave (
    input  En, Mode, LdStb, LdSel, LdVal, Sync,
    output ClkOut, Tick, Pend
  );
endinterface

// File: rtl/multi_clk_div_channel.sv
// One divider channel: counter, active and shadow divisor, pending flag,
// and the registered ClkOut/Tick generation.
//   clk, rst : board clock, asynchronous active-high reset
//   en, mode : channel enable and output mode
//   ld       : write ld_val into the shadow divisor this cycle
//   sync     : restart the channel and apply any pending divisor
//   clk_out  : divided output, tick : terminal-count strobe
//   pend     : shadow divisor not yet applied
module clk_div_channel
  import multi_clk_div_pkg::*;
#(
  parameter int            CW      = 26,
  parameter logic [CW-1:0] DEF_DIV = CW'(2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  mode_e         mode,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          sync,
  output logic          clk_out,
  output logic          tick,
  output logic          pend
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] div;
  logic [CW-1:0] shadow;
  logic          active;
  logic          tc;
  logic          apply;

  assign active = en && (div != '0);
  assign tc     = active && (cnt == div - CW'(1));
  // A new divisor only takes over at a period boundary (TC), while the
  // channel is idle, or on Sync, so a running period is never truncated.
  assign apply  = pend && (sync || tc || !active);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values and the block order does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pend    <= 1'b0;
      div     <= DEF_DIV;
      shadow  <= DEF_DIV;
    end else begin
      if (sync) begin
        cnt     <= '0;
        clk_out <= 1'b0;
        tick    <= 1'b0;
      end else if (tc) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (mode == MODE_PULSE) ? 1'b1 : ~clk_out;
      end else begin
        tick <= 1'b0;
        if (active) cnt <= cnt + CW'(1);
        // Pulse mode output is only high on the TC cycle; toggle mode holds.
        if (mode == MODE_PULSE) clk_out <= 1'b0;
      end

      if (apply) div <= shadow;

      // A load on the same edge as an apply keeps the new value pending.
      if (ld) begin
        shadow <= ld_val;
        pend   <= 1'b1;
      end else if (apply) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider with clock-enable ticks.
//   Clk    : board clock
//   DivRst : asynchronous reset, active-high
//   bus    : control/status bundle (enables, modes, divisor load, Sync,
//            ClkOut, Tick, Pend), one bit per channel where applicable
// Decodes the divisor load select with a range check, fans Sync out to all
// channels and instantiates NCH independent channels.
module multi_clk_div
  import multi_clk_div_pkg::*;
#(
  parameter int          NCH       = 4,
  parameter int          CW        = 26,
  parameter int unsigned BOARD_CLK = BOARD_CLK_DEF,
  parameter int unsigned DEF_DIV   = BOARD_CLK / 2,
  parameter int          SELW      = sel_width(NCH)
) (
  input logic            Clk,
  input logic            DivRst,
  multi_clk_div_if.slave bus
);

  if (NCH < 1 || NCH > 16 || SELW < sel_width(NCH) ||
      DEF_DIV == 0 || 64'(DEF_DIV) >= (64'd1 << CW)) begin : g_bad_params
    $error("multi_clk_div: illegal NCH/SELW or DEF_DIV zero or wider than CW");
  end

  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  logic           sel_ok;
  logic [NCH-1:0] ld;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] pend;

  // Out-of-range selects (possible when NCH is not a power of two) are dropped.
  assign sel_ok = ({1'b0, bus.LdSel} < NCH_W);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ld[i] = bus.LdStb && sel_ok && (bus.LdSel == SELW'(i));

    clk_div_channel #(
      .CW      (CW),
      .DEF_DIV (CW'(DEF_DIV))
    ) u_ch (
      .clk     (Clk),
      .rst     (DivRst),
      .en      (bus.En[i]),
      .mode    (mode_e'(bus.Mode[i])),
      .ld      (ld[i]),
      .ld_val  (bus.LdVal),
      .sync    (bus.Sync),
      .clk_out (clk_out[i]),
      .tick    (tick[i]),
      .pend    (pend[i])
    );
  end

  assign bus.ClkOut = clk_out;
  assign bus.Tick   = tick;
  assign bus.Pend   = pend;

endmodule

// File: tb/tb_multi_clk_div.sv
// Self-checking bench for multi_clk_div (NCH=2, CW=4, DEF_DIV=3) plus a
// second NCH=3 instance used for out-of-range load selects.
// The reference model tracks, per channel, how many active edges remain
// until the next terminal count, and derives all outputs from that.
module tb_multi_clk_div;
  import multi_clk_div_pkg::*;

  localparam int NCH   = 2;
  localparam int CW    = 4;
  localparam int DEF   = 3;
  localparam int SELW  = sel_width(NCH);
  localparam int NCH3  = 3;
  localparam int SELW3 = sel_width(NCH3);
  localparam int MODV  = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multi_clk_div_if #(.NCH(NCH), .CW(CW), .SELW(SELW)) bus ();
  multi_clk_div_if #(.NCH(NCH3), .CW(CW), .SELW(SELW3)) bus3 ();

  multi_clk_div #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF), .SELW(SELW)) dut (
    .Clk    (clk),
    .DivRst (rst),
    .bus    (bus.slave)
  );

  multi_clk_div #(.NCH(NCH3), .CW(CW), .DEF_DIV(DEF), .SELW(SELW3)) dut3 (
    .Clk    (clk),
    .DivRst (rst),
    .bus    (bus3.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state: edges remaining until TC (1..MODV), divisors, flags.
  int rem_m  [NCH];
  int div_m  [NCH];
  int sh_m   [NCH];
  bit pend_m [NCH];
  bit co_m   [NCH];
  bit tk_m   [NCH];
  int edges3;  // edges since reset release for the untouched NCH=3 instance

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int wrapm(int x);
    int r;
    r = ((x % MODV) + MODV) % MODV;
    return (r == 0) ? MODV : r;
  endfunction

  function automatic int cnt_of(int c);
    return ((div_m[c] - rem_m[c]) % MODV + MODV) % MODV;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      div_m[c]  = DEF;
      sh_m[c]   = DEF;
      rem_m[c]  = DEF;
      pend_m[c] = 1'b0;
      co_m[c]   = 1'b0;
      tk_m[c]   = 1'b0;
    end
    edges3 = 0;
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit act, sy, tc, ld, app, pulse;
      int nd;
      act   = bus.En[c] && (div_m[c] != 0);
      sy    = bus.Sync;
      pulse = bus.Mode[c];
      tc    = act && !sy && (rem_m[c] == 1);
      ld    = bus.LdStb && (int'(bus.LdSel) == c);
      app   = pend_m[c] && (sy || tc || !act);
      nd    = app ? sh_m[c] : div_m[c];
      if (sy) begin
        co_m[c]  = 1'b0;
        tk_m[c]  = 1'b0;
        rem_m[c] = wrapm(nd);
      end else if (tc) begin
        tk_m[c]  = 1'b1;
        co_m[c]  = pulse ? 1'b1 : ~co_m[c];
        rem_m[c] = wrapm(nd);
      end else if (act) begin
        tk_m[c]  = 1'b0;
        rem_m[c] = rem_m[c] - 1;
        if (pulse) co_m[c] = 1'b0;
      end else begin
        tk_m[c] = 1'b0;
        if (pulse) co_m[c] = 1'b0;
        // Counter holds while the divisor moves: distance to TC shifts.
        if (app) rem_m[c] = wrapm(rem_m[c] + nd - div_m[c]);
      end
      div_m[c] = nd;
      if (ld) begin
        sh_m[c]   = int'(bus.LdVal);
        pend_m[c] = 1'b1;
      end else if (app) begin
        pend_m[c] = 1'b0;
      end
    end
    edges3++;
  endtask

  task automatic compare();
    logic [NCH-1:0]  e_co, e_tk, e_pd;
    logic [NCH3-1:0] e_co3, e_tk3;
    for (int c = 0; c < NCH; c++) begin
      e_co[c] = co_m[c];
      e_tk[c] = tk_m[c];
      e_pd[c] = pend_m[c];
    end
    // All three channels of dut3 run the default divisor in toggle mode.
    e_tk3 = (edges3 > 0 && edges3 % DEF == 0) ? '1 : '0;
    e_co3 = ((edges3 / DEF) % 2 == 1) ? '1 : '0;
    check("clk_out", 32'(bus.ClkOut), 32'(e_co));
    check("tick",    32'(bus.Tick),   32'(e_tk));
    check("pend",    32'(bus.Pend),   32'(e_pd));
    check("clk_out3", 32'(bus3.ClkOut), 32'(e_co3));
    check("tick3",    32'(bus3.Tick),   32'(e_tk3));
    check("pend3",    32'(bus3.Pend),   32'd0);
  endtask

  task automatic step();
    if (!rst) model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    bit found;
    bus.En     = 2'b11;
    bus.Mode   = 2'b00;
    bus.LdStb  = 1'b0;
    bus.LdSel  = '0;
    bus.LdVal  = '0;
    bus.Sync   = 1'b0;
    bus3.En    = 3'b111;
    bus3.Mode  = 3'b000;
    bus3.LdStb = 1'b0;
    bus3.LdSel = '0;
    bus3.LdVal = '0;
    bus3.Sync  = 1'b0;
    rst = 1'b1;
    model_reset();

    // Reset state, then release between edges: square wave of period 6.
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) step();

    // Channel 1 to pulse mode.
    bus.Mode = 2'b10;
    repeat (9) step();

    // Load 5 into channel 0 while its counter is at 1.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (cnt_of(0) == 1) found = 1'b1;
      else step();
    end
    check("cnt0_reached_1", 32'(found), 32'd1);
    bus.LdStb = 1'b1;
    bus.LdSel = SELW'(0);
    bus.LdVal = CW'(5);
    step();
    bus.LdStb = 1'b0;
    repeat (15) step();

    // Load 7 into channel 1 (plus an out-of-range load on dut3), then Sync.
    bus.Mode   = 2'b00;
    bus.LdStb  = 1'b1;
    bus.LdSel  = SELW'(1);
    bus.LdVal  = CW'(7);
    bus3.LdStb = 1'b1;
    bus3.LdSel = SELW3'(3);
    bus3.LdVal = CW'(5);
    step();
    bus.LdStb  = 1'b0;
    bus3.LdStb = 1'b0;
    repeat (2) step();
    bus.Sync = 1'b1;
    step();
    bus.Sync = 1'b0;
    repeat (16) step();

    // Asynchronous reset pulse between clock edges, mid-count.
    repeat (4) step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    #2;
    rst = 1'b0;
    repeat (9) step();

    // Divisor 1 (toggle every cycle), then divisor 0 (channel stalls).
    bus.LdStb = 1'b1;
    bus.LdSel = SELW'(0);
    bus.LdVal = CW'(1);
    step();
    bus.LdStb = 1'b0;
    repeat (8) step();
    bus.LdStb = 1'b1;
    bus.LdVal = CW'(0);
    step();
    bus.LdStb = 1'b0;
    repeat (8) step();

    // Randomised traffic on the NCH=2 instance; dut3 only sees bad selects.
    for (int k = 0; k < 400; k++) begin
      bus.En     = NCH'($urandom);
      bus.Mode   = NCH'($urandom);
      bus.LdStb  = ($urandom_range(0, 3) == 0);
      bus.LdSel  = SELW'($urandom);
      bus.LdVal  = CW'($urandom);
      bus.Sync   = ($urandom_range(0, 15) == 0);
      bus3.LdStb = ($urandom_range(0, 3) == 0);
      bus3.LdSel = SELW3'(3);
      bus3.LdVal = CW'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
